// File: rtl/lsu_ctrl.sv
// Load/store unit between the MEM stage and dmem: one request at a time, alignment/range
// checking, read-modify-write for byte and halfword stores, held response handshake.
module lsu_ctrl #(
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wr_data,
  output logic        dmem_mem_wr,
  output logic        dmem_mem_rd,
  output logic [2:0]  dmem_mask,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, RMW_WR, STW, ERR, RESP} state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;
  logic [31:0] merged;
  logic [2:0]  funct3_q;
  logic        req_err;

  // Decode of the incoming request, evaluated in the accept cycle itself.
  always_comb begin
    req_err = 1'b0;
    if (req_funct3[1:0] == 2'b01 && req_addr[0])
      req_err = 1'b1;
    if (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00)
      req_err = 1'b1;
    if ({2'b00, req_addr[31:2]} >= 32'(DMEM_WORDS))
      req_err = 1'b1;
    if (req_we) begin
      if (!(req_funct3 inside {3'b000, 3'b001, 3'b010}))
        req_err = 1'b1;
    end else if (req_funct3 inside {3'b011, 3'b110, 3'b111}) begin
      req_err = 1'b1;
    end
  end

  always_comb begin
    merged = merge_q;
    if (funct3_q[1:0] == 2'b00) begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  // Write strobe is qualified by rst so a reset landing on a write cycle abandons it.
  always_comb begin
    dmem_addr    = (state == IDLE) ? 32'd0 : addr_q;
    dmem_wr_data = 32'd0;
    dmem_mem_wr  = 1'b0;
    dmem_mem_rd  = 1'b0;
    dmem_mask    = 3'b000;
    case (state)
      LOAD: begin
        dmem_mem_rd = 1'b1;
        dmem_mask   = funct3_q;
      end
      RMW_RD: begin
        dmem_mem_rd = 1'b1;
        dmem_mask   = 3'b010;
      end
      RMW_WR: begin
        dmem_mem_wr  = !rst;
        dmem_mask    = 3'b010;
        dmem_wr_data = merged;
      end
      STW: begin
        dmem_mem_wr  = !rst;
        dmem_mask    = 3'b010;
        dmem_wr_data = wdata_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      funct3_q   <= 3'b000;
      merge_q    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            funct3_q   <= req_funct3;
            req_ready  <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            if (req_err)
              state <= ERR;
            else if (!req_we)
              state <= LOAD;
            else if (req_funct3 == 3'b010)
              state <= STW;
            else
              state <= RMW_RD;
          end
        end
        LOAD: begin
          resp_rdata <= dmem_rdata;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RMW_RD: begin
          merge_q <= dmem_rdata;
          state   <= RMW_WR;
        end
        RMW_WR, STW: begin
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        ERR: begin
          resp_err   <= 1'b1;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
